// File: rtl/contrast_stretch_ctrl.sv
// rtl/contrast_stretch_ctrl.sv - two-pass contrast-stretch sequencer feeding an 8-bit divider
module contrast_stretch_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PIXELS = 16384,
  parameter int CNT_WIDTH  = 15
) (
  input  logic                    clk_i_cs,
  input  logic                    rst_i_cs,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   pix_i,
  input  logic                    pix_valid_i,
  output logic                    pix_ready_o,
  output logic [DATA_WIDTH-1:0]   pix_o,
  output logic                    pix_valid_o,
  input  logic                    pix_ready_i,
  output logic                    div_en_o,
  output logic [DATA_WIDTH-1:0]   div_b_o,
  output logic [2*DATA_WIDTH-1:0] div_q_o,
  input  logic [DATA_WIDTH-1:0]   div_result_i,
  input  logic                    div_done_i,
  output logic [DATA_WIDTH-1:0]   min_o,
  output logic [DATA_WIDTH-1:0]   max_o,
  output logic                    busy_o,
  output logic                    frame_done_o
);

  localparam logic [CNT_WIDTH-1:0]    LAST_PIX = CNT_WIDTH'(NUM_PIXELS - 1);
  localparam logic [2*DATA_WIDTH-1:0] SCALE    = (2*DATA_WIDTH)'((2**DATA_WIDTH) - 1);

  typedef enum logic [3:0] {
    IDLE, SCAN, CALC, FETCH, DIV_REQ, DIV_WAIT, DIV_CLR, OUT, DONE
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   min_r;
  logic [DATA_WIDTH-1:0]   max_r;
  logic [DATA_WIDTH-1:0]   range_r;
  logic [DATA_WIDTH-1:0]   diff;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [2*DATA_WIDTH-1:0] dividend;
  logic                    accept;

  assign accept = pix_valid_i & pix_ready_o;

  // Out-of-range pass-2 pixels are clamped so the quotient can never exceed full scale.
  always_comb begin
    if (pix_i < min_r)
      diff = '0;
    else if (pix_i > max_r)
      diff = range_r;
    else
      diff = pix_i - min_r;
  end

  assign dividend = {{DATA_WIDTH{1'b0}}, diff} * SCALE;

  always_ff @(posedge clk_i_cs) begin
    if (rst_i_cs) begin
      state        <= IDLE;
      min_r        <= '1;
      max_r        <= '0;
      range_r      <= '0;
      cnt          <= '0;
      pix_ready_o  <= 1'b0;
      pix_o        <= '0;
      pix_valid_o  <= 1'b0;
      div_en_o     <= 1'b0;
      div_b_o      <= '0;
      div_q_o      <= '0;
      min_o        <= '0;
      max_o        <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            min_r       <= '1;
            max_r       <= '0;
            cnt         <= '0;
            pix_ready_o <= 1'b1;
            busy_o      <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (accept) begin
            if (pix_i < min_r) min_r <= pix_i;
            if (pix_i > max_r) max_r <= pix_i;
            if (cnt == LAST_PIX) begin
              cnt         <= '0;
              pix_ready_o <= 1'b0;
              state       <= CALC;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        CALC: begin
          range_r     <= max_r - min_r;
          min_o       <= min_r;
          max_o       <= max_r;
          pix_ready_o <= 1'b1;
          state       <= FETCH;
        end
        FETCH: begin
          if (accept) begin
            pix_ready_o <= 1'b0;
            // A flat frame has nothing to stretch; skip the divider entirely.
            if (range_r == '0) begin
              pix_o       <= '0;
              pix_valid_o <= 1'b1;
              state       <= OUT;
            end else begin
              div_q_o  <= dividend;
              div_b_o  <= range_r;
              div_en_o <= 1'b1;
              state    <= DIV_REQ;
            end
          end
        end
        DIV_REQ: begin
          div_en_o <= 1'b0;
          state    <= DIV_WAIT;
        end
        DIV_WAIT: begin
          if (div_done_i) begin
            pix_o <= div_result_i;
            state <= DIV_CLR;
          end
        end
        DIV_CLR: begin
          // The divider may hold done for two cycles; wait for it to fall.
          if (!div_done_i) begin
            pix_valid_o <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (pix_ready_i) begin
            pix_valid_o <= 1'b0;
            if (cnt == LAST_PIX) begin
              cnt          <= '0;
              frame_done_o <= 1'b1;
              state        <= DONE;
            end else begin
              cnt         <= cnt + CNT_WIDTH'(1);
              pix_ready_o <= 1'b1;
              state       <= FETCH;
            end
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_contrast_stretch_ctrl.sv
// tb/tb_contrast_stretch_ctrl.sv - self-checking bench for contrast_stretch_ctrl with divider and source models
module tb_contrast_stretch_ctrl;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [7:0]  pix_i;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic [7:0]  pix_o;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic        div_en_o;
  logic [7:0]  div_b_o;
  logic [15:0] div_q_o;
  logic [7:0]  div_result_i;
  logic        div_done_i;
  logic [7:0]  min_o;
  logic [7:0]  max_o;
  logic        busy_o;
  logic        frame_done_o;

  int checks = 0;
  int errors = 0;
  int cur_frame[N];
  int exp_out[$];
  int exp_q[$];
  int exp_b[$];
  int got[$];
  int exp_min, exp_max, exp_en;
  int en_cnt = 0;
  int done_cnt = 0;
  int lat_lo = 0;
  int lat_hi = 0;
  bit feed_gaps = 0;
  bit abort = 0;
  bit fd_prev = 0;

  contrast_stretch_ctrl #(.DATA_WIDTH(8), .NUM_PIXELS(N), .CNT_WIDTH(3)) dut (
    .clk_i_cs(clk), .rst_i_cs(rst), .start_i(start_i),
    .pix_i(pix_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .pix_o(pix_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
    .div_en_o(div_en_o), .div_b_o(div_b_o), .div_q_o(div_q_o),
    .div_result_i(div_result_i), .div_done_i(div_done_i),
    .min_o(min_o), .max_o(max_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stretch rule: clamp into [min,max], scale the offset to full range, truncate.
  task automatic build_model();
    int mn, mx, rg, d;
    mn = 255;
    mx = 0;
    for (int i = 0; i < N; i++) begin
      if (cur_frame[i] < mn) mn = cur_frame[i];
      if (cur_frame[i] > mx) mx = cur_frame[i];
    end
    rg = mx - mn;
    exp_min = mn;
    exp_max = mx;
    exp_en  = (rg == 0) ? 0 : N;
    for (int i = 0; i < N; i++) begin
      d = (cur_frame[i] < mn) ? 0 : (cur_frame[i] > mx) ? rg : cur_frame[i] - mn;
      if (rg != 0) begin
        exp_q.push_back(d * 255);
        exp_b.push_back(rg);
      end
      exp_out.push_back((rg == 0) ? 0 : (d * 255) / rg);
    end
  endtask

  // Output scoreboard and frame-done monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && pix_valid_o && pix_ready_i) begin
        got.push_back(int'(pix_o));
        if (exp_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pix %0d expected no output", pix_o);
        end else begin
          check("pix_out", int'(pix_o), exp_out.pop_front());
        end
      end
      if (frame_done_o) begin
        done_cnt++;
        check("frame_done_width", int'(fd_prev), 0);
      end
      fd_prev = frame_done_o;
    end
  end

  // Divider model: random latency, done held for two cycles.
  initial begin
    int qv, bv, lat;
    div_done_i   = 1'b0;
    div_result_i = '0;
    forever begin
      @(negedge clk);
      if (!rst && div_en_o) begin
        en_cnt++;
        qv = int'(div_q_o);
        bv = int'(div_b_o);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_div_en: got q %0d b %0d expected no request", qv, bv);
        end else begin
          check("div_q", qv, exp_q.pop_front());
          check("div_b", bv, exp_b.pop_front());
        end
        lat = int'($urandom_range(lat_hi, lat_lo));
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (rst) break;
          check("div_en_wait", int'(div_en_o), 0);
          check("div_q_stable", int'(div_q_o), qv);
          check("div_b_stable", int'(div_b_o), bv);
        end
        if (!rst) begin
          div_result_i = (bv == 0) ? 8'd0 : 8'((qv / bv));
          div_done_i   = 1'b1;
          @(negedge clk);
          check("div_en_done", int'(div_en_o), 0);
          @(negedge clk);
          div_done_i = 1'b0;
        end
      end
    end
  end

  // Source: presents the frame twice, holding each pixel until accepted.
  task automatic feed();
    int  i;
    int  budget;
    bit  acc;
    i = 0;
    budget = 0;
    while (i < 2 * N && !abort && budget < 5000) begin
      pix_i       = 8'(cur_frame[i % N]);
      pix_valid_i = feed_gaps ? ($urandom_range(1, 0) == 1) : 1'b1;
      @(negedge clk);
      acc = pix_valid_i && pix_ready_o;
      @(posedge clk);
      #1;
      if (acc) i++;
      budget++;
    end
    pix_valid_i = 1'b0;
    if (!abort) check("feed_budget", int'(budget < 5000), 1);
  endtask

  task automatic set_frame(input int a, input int b, input int c, input int d);
    cur_frame[0] = a;
    cur_frame[1] = b;
    cur_frame[2] = c;
    cur_frame[3] = d;
  endtask

  task automatic check_zero();
    check("rst_pix_ready", int'(pix_ready_o), 0);
    check("rst_pix_o", int'(pix_o), 0);
    check("rst_pix_valid", int'(pix_valid_o), 0);
    check("rst_div_en", int'(div_en_o), 0);
    check("rst_div_b", int'(div_b_o), 0);
    check("rst_div_q", int'(div_q_o), 0);
    check("rst_min", int'(min_o), 0);
    check("rst_max", int'(max_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_frame_done", int'(frame_done_o), 0);
  endtask

  task automatic run_frame(input bit gaps, input bit stall, input bit restart);
    int         guard;
    int         d0;
    logic [7:0] held;
    build_model();
    got.delete();
    en_cnt    = 0;
    d0        = done_cnt;
    feed_gaps = gaps;
    if (stall) pix_ready_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("busy_after_start", int'(busy_o), 1);
    fork
      feed();
    join_none
    if (restart) begin
      repeat (2) @(posedge clk);
      #1;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    if (stall) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!pix_valid_o && guard < 2000);
      check("stall_reached", int'(pix_valid_o), 1);
      held = pix_o;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check("stall_valid", int'(pix_valid_o), 1);
        check("stall_pix", int'(pix_o), int'(held));
        check("stall_ready", int'(pix_ready_o), 0);
        check("stall_div_en", int'(div_en_o), 0);
      end
      @(posedge clk);
      #1;
      pix_ready_i = 1'b1;
    end
    guard = 0;
    while (done_cnt == d0 && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("frame_timeout", int'(guard < 20000), 1);
    check("frame_done_count", done_cnt - d0, 1);
    check("out_count", got.size(), N);
    check("div_en_count", en_cnt, exp_en);
    check("exp_drained", exp_out.size(), 0);
    check("min_o", int'(min_o), exp_min);
    check("max_o", int'(max_o), exp_max);
    check("busy_idle", int'(busy_o), 0);
  endtask

  initial begin
    int guard;
    rst         = 1'b1;
    start_i     = 1'b0;
    pix_i       = '0;
    pix_valid_i = 1'b0;
    pix_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ramp frame with hand-computed results.
    set_frame(50, 100, 150, 200);
    run_frame(1'b0, 1'b0, 1'b0);
    check("ramp_min", int'(min_o), 50);
    check("ramp_max", int'(max_o), 200);
    check("ramp_div_b", int'(div_b_o), 150);
    check("ramp_last_q", int'(div_q_o), 38250);
    if (got.size() == N) begin
      check("ramp_out0", got[0], 0);
      check("ramp_out1", got[1], 85);
      check("ramp_out2", got[2], 170);
      check("ramp_out3", got[3], 255);
    end

    // Flat frame never touches the divider.
    set_frame(77, 77, 77, 77);
    run_frame(1'b0, 1'b0, 1'b0);
    check("flat_no_div", en_cnt, 0);
    if (got.size() == N) check("flat_out3", got[3], 0);

    // Random divider latency.
    lat_lo = 0;
    lat_hi = 40;
    set_frame(50, 100, 150, 200);
    run_frame(1'b0, 1'b0, 1'b0);
    set_frame(30, 200, 10, 90);
    run_frame(1'b0, 1'b0, 1'b0);

    // Downstream backpressure.
    lat_lo = 3;
    lat_hi = 3;
    set_frame(12, 40, 220, 99);
    run_frame(1'b0, 1'b1, 1'b0);

    // Reset while waiting on the divider.
    lat_lo = 20;
    lat_hi = 20;
    set_frame(50, 100, 150, 200);
    build_model();
    en_cnt = 0;
    feed_gaps = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    fork
      feed();
    join_none
    guard = 0;
    while (en_cnt == 0 && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("reach_div_wait", en_cnt, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero();
    abort = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b0;
    pix_valid_i = 1'b0;
    exp_out.delete();
    exp_q.delete();
    exp_b.delete();
    lat_lo = 0;
    lat_hi = 5;
    set_frame(0, 255, 0, 255);
    run_frame(1'b0, 1'b0, 1'b0);
    if (got.size() == N) begin
      check("post_rst_out0", got[0], 0);
      check("post_rst_out1", got[1], 255);
      check("post_rst_out2", got[2], 0);
      check("post_rst_out3", got[3], 255);
    end

    // Start pulsed mid-scan with a bursty source.
    set_frame(180, 5, 77, 130);
    run_frame(1'b1, 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
